// File: rtl/ipf_conv_engine_if.sv
// ipf_conv_engine_if: command, image-row and weight-word bus
// into the row-streaming convolution engine.
interface ipf_conv_engine_if;
    logic [1:0]  ctrl;
    logic        i_valid;
    logic [63:0] i_data;
    logic        w_valid;
    logic [63:0] w_data;

    modport master (
        output ctrl, i_valid, i_data, w_valid, w_data
    );

    modport slave (
        input ctrl, i_valid, i_data, w_valid, w_data
    );
endinterface

// File: rtl/ipf_conv_engine.sv
// ipf_conv_engine: 3x3 / 5x5 row-streaming convolution with
// a kernel bank and an 8-slot overwrite/accumulate result register.
module ipf_conv_engine #(
    parameter int In_Width   = 8,
    parameter int Out_Width  = 9,
    parameter int Addr_Width = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    ipf_conv_engine_if.slave             bus,
    input  logic [1:0]                   Wsize,
    input  logic [1:0]                   RLPadding,
    input  logic                         stride,
    input  logic [3:0]                   wgroup,
    input  logic [2:0]                   wround,
    output logic                         res_valid,
    output logic [8*16*8*Out_Width-1:0]  result,
    output logic                         finish,
    output logic [8*Out_Width-1:0]       tmp_result0,
    output logic [8*Out_Width-1:0]       tmp_result1,
    output logic [8*Out_Width-1:0]       tmp_result2,
    output logic [8*Out_Width-1:0]       tmp_result3,
    output logic [8*Out_Width-1:0]       tmp_result4,
    output logic [8*Out_Width-1:0]       tmp_result5,
    output logic [8*Out_Width-1:0]       tmp_result6,
    output logic [8*Out_Width-1:0]       tmp_result7,
    output logic [8*Out_Width-1:0]       tmp_result8,
    output logic [8*Out_Width-1:0]       tmp_result9,
    output logic [8*Out_Width-1:0]       tmp_result10,
    output logic [8*Out_Width-1:0]       tmp_result11,
    output logic [8*Out_Width-1:0]       tmp_result12,
    output logic [8*Out_Width-1:0]       tmp_result13,
    output logic [8*Out_Width-1:0]       tmp_result14,
    output logic [8*Out_Width-1:0]       tmp_result15
);
    localparam int RowW   = 8 * Out_Width;
    localparam int SlotW  = 16 * RowW;
    localparam int NWords = 25;
    localparam int NBytes = NWords * 8;
    localparam logic [Addr_Width-1:0] LastPtr = Addr_Width'(NWords);

    logic [63:0]           wmem [NWords];
    logic [Addr_Width-1:0] wptr;
    logic [In_Width-1:0]   wbyte [NBytes];

    logic [63:0]    lb [4];
    logic [2:0]     fill;
    logic           ctrl1_q;
    logic           phase_q;
    logic           produced_q;
    logic [2:0]     slot_q;
    logic [RowW-1:0]  tmp_q [16];
    logic [SlotW-1:0] res_q [8];

    logic       c1;
    logic       c0;
    logic       k5;
    logic       start;
    logic       qual;
    logic       produce;
    logic       eff_phase;
    logic [2:0] eff_slot;
    logic [2:0] need;
    logic [2:0] kfill;

    logic [63:0]      win [5];
    logic [RowW-1:0]  lane_row [16];
    logic [SlotW-1:0] slot_nxt;

    int kk;
    int pp;
    int nv;
    int cs;
    int col;
    int widx;
    logic [15:0] prod;
    logic [20:0] sum;

    logic [Out_Width-1:0] o_l;
    logic [Out_Width-1:0] n_l;
    logic [Out_Width:0]   s_l;

    logic unused_wround;

    assign unused_wround = ^wround;

    // Command decode; X/Z or 2/3 on ctrl fall through as hold.
    always_comb begin
        c1 = 1'b0;
        c0 = 1'b0;
        if (bus.ctrl == 2'b01) c1 = 1'b1;
        if (bus.ctrl == 2'b00) c0 = 1'b1;
        k5        = (Wsize == 2'b01);
        need      = k5 ? 3'd4 : 3'd2;
        kfill     = k5 ? 3'd5 : 3'd3;
        start     = c1 && !ctrl1_q;
        qual      = bus.i_valid && c1 && (fill >= need);
        eff_phase = start ? 1'b0 : phase_q;
        eff_slot  = start ? 3'd0 : slot_q;
        produce   = qual && (!stride || !eff_phase);
    end

    // Weight word pointer: restarts whenever the load burst breaks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
        end else if (!bus.w_valid) begin
            wptr <= '0;
        end else if (wptr < LastPtr) begin
            wptr <= wptr + Addr_Width'(1);
        end
    end

    // Weight storage survives reset so a reset need not reload kernels.
    always_ff @(posedge clk) begin
        if (bus.w_valid && (wptr < LastPtr)) begin
            wmem[wptr[4:0]] <= bus.w_data;
        end
    end

    // Byte view of the weight memory, indexed by weight number.
    always_comb begin
        for (int i = 0; i < NBytes; i++) begin
            wbyte[i] = wmem[i/8][(i%8)*In_Width +: In_Width];
        end
    end

    // Window rows: the newest K-1 buffered rows plus the live row.
    always_comb begin
        for (int r = 0; r < 5; r++) win[r] = '0;
        if (k5) begin
            win[0] = lb[0];
            win[1] = lb[1];
            win[2] = lb[2];
            win[3] = lb[3];
            win[4] = bus.i_data;
        end else begin
            win[0] = lb[2];
            win[1] = lb[3];
            win[2] = bus.i_data;
        end
    end

    // Per-kernel, per-lane multiply-accumulate with padding and saturation.
    always_comb begin
        kk   = k5 ? 5 : 3;
        pp   = (kk - 1) / 2;
        nv   = (8 - kk + 1)
             + pp * ((RLPadding[0] ? 1 : 0) + (RLPadding[1] ? 1 : 0));
        cs   = 0;
        col  = 0;
        widx = 0;
        prod = '0;
        sum  = '0;
        if (stride) nv = (nv + 1) / 2;
        for (int k = 0; k < 16; k++) begin
            lane_row[k] = '0;
            for (int j = 0; j < 8; j++) begin
                sum = '0;
                cs  = j * (stride ? 2 : 1) - (RLPadding[0] ? pp : 0);
                if (j < nv && !(k5 && k >= 8)) begin
                    for (int r = 0; r < 5; r++) begin
                        for (int c = 0; c < 5; c++) begin
                            col = cs + c;
                            if (r < kk && c < kk && col >= 0 && col < 8) begin
                                widx = k5 ? 25*k + 5*r + c : 9*k + 3*r + c;
                                prod = 16'(win[r][col*In_Width +: In_Width])
                                     * 16'(wbyte[widx]);
                                sum  = sum + 21'(prod);
                            end
                        end
                    end
                end
                lane_row[k][j*Out_Width +: Out_Width] =
                    (|sum[20:8+Out_Width]) ? '1 : sum[8 +: Out_Width];
            end
        end
    end

    // New slot contents: overwrite, or saturating add onto the old slot.
    always_comb begin
        slot_nxt = '0;
        o_l = '0;
        n_l = '0;
        s_l = '0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 8; j++) begin
                o_l = res_q[eff_slot][k*RowW + j*Out_Width +: Out_Width];
                n_l = lane_row[k][j*Out_Width +: Out_Width];
                s_l = {1'b0, o_l} + {1'b0, n_l};
                if (k5 && k >= 8) begin
                    slot_nxt[k*RowW + j*Out_Width +: Out_Width] = '0;
                end else if (wgroup == 4'd0) begin
                    slot_nxt[k*RowW + j*Out_Width +: Out_Width] = n_l;
                end else begin
                    slot_nxt[k*RowW + j*Out_Width +: Out_Width] =
                        s_l[Out_Width] ? '1 : s_l[Out_Width-1:0];
                end
            end
        end
    end

    // Line buffer shifts on every valid row, independent of the command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 4; r++) lb[r] <= '0;
            fill <= '0;
        end else if (bus.i_valid) begin
            lb[0] <= lb[1];
            lb[1] <= lb[2];
            lb[2] <= lb[3];
            lb[3] <= bus.i_data;
            if (fill < kfill) fill <= fill + 3'd1;
        end
    end

    // Run sequencing: slot pointer, stride phase, end-of-run flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl1_q    <= 1'b0;
            phase_q    <= 1'b0;
            produced_q <= 1'b0;
            slot_q     <= '0;
            res_valid  <= 1'b0;
            finish     <= 1'b0;
        end else begin
            ctrl1_q   <= c1;
            res_valid <= ctrl1_q && !c1 && produced_q;
            if (c1) begin
                finish <= 1'b0;
            end else if (c0) begin
                finish <= 1'b1;
            end
            if (start) begin
                slot_q     <= '0;
                phase_q    <= 1'b0;
                produced_q <= 1'b0;
            end
            if (qual) phase_q <= ~eff_phase;
            if (produce) begin
                slot_q     <= eff_slot + 3'd1;
                produced_q <= 1'b1;
            end
        end
    end

    // Output rows and result slots captured on each produced row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) tmp_q[k] <= '0;
            for (int s = 0; s < 8; s++) res_q[s] <= '0;
        end else if (produce) begin
            for (int k = 0; k < 16; k++) tmp_q[k] <= lane_row[k];
            res_q[eff_slot] <= slot_nxt;
        end
    end

    // Flatten the slot array onto the wide result port.
    always_comb begin
        result = '0;
        for (int s = 0; s < 8; s++) result[s*SlotW +: SlotW] = res_q[s];
    end

    assign tmp_result0  = tmp_q[0];
    assign tmp_result1  = tmp_q[1];
    assign tmp_result2  = tmp_q[2];
    assign tmp_result3  = tmp_q[3];
    assign tmp_result4  = tmp_q[4];
    assign tmp_result5  = tmp_q[5];
    assign tmp_result6  = tmp_q[6];
    assign tmp_result7  = tmp_q[7];
    assign tmp_result8  = tmp_q[8];
    assign tmp_result9  = tmp_q[9];
    assign tmp_result10 = tmp_q[10];
    assign tmp_result11 = tmp_q[11];
    assign tmp_result12 = tmp_q[12];
    assign tmp_result13 = tmp_q[13];
    assign tmp_result14 = tmp_q[14];
    assign tmp_result15 = tmp_q[15];
endmodule

// File: tb/tb_ipf_conv_engine.sv
// tb_ipf_conv_engine: directed vectors with hand-computed rows
// for the convolution engine.
module tb_ipf_conv_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ipf_conv_engine_if bus();

    logic [1:0]    Wsize;
    logic [1:0]    RLPadding;
    logic          stride;
    logic [3:0]    wgroup;
    logic [2:0]    wround;
    logic          res_valid;
    logic          finish;
    logic [9215:0] result;
    logic [71:0]   tr [16];

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] P10 = 64'h1010_1010_1010_1010;
    localparam logic [63:0] P20 = 64'h2020_2020_2020_2020;
    localparam logic [63:0] PFF = 64'hFFFF_FFFF_FFFF_FFFF;

    ipf_conv_engine dut (
        .clk(clk), .rst(rst), .bus(bus),
        .Wsize(Wsize), .RLPadding(RLPadding), .stride(stride),
        .wgroup(wgroup), .wround(wround),
        .res_valid(res_valid), .result(result), .finish(finish),
        .tmp_result0(tr[0]),   .tmp_result1(tr[1]),
        .tmp_result2(tr[2]),   .tmp_result3(tr[3]),
        .tmp_result4(tr[4]),   .tmp_result5(tr[5]),
        .tmp_result6(tr[6]),   .tmp_result7(tr[7]),
        .tmp_result8(tr[8]),   .tmp_result9(tr[9]),
        .tmp_result10(tr[10]), .tmp_result11(tr[11]),
        .tmp_result12(tr[12]), .tmp_result13(tr[13]),
        .tmp_result14(tr[14]), .tmp_result15(tr[15])
    );

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] row(input int v, input int n);
        logic [71:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[j*9 +: 9] = (j < n) ? 9'(v) : 9'd0;
        return r;
    endfunction

    function automatic logic [71:0] prow(input int e, input int m);
        logic [71:0] r;
        r = row(m, 8);
        r[0 +: 9]  = 9'(e);
        r[63 +: 9] = 9'(e);
        return r;
    endfunction

    function automatic logic [71:0] slot_row(input int s, input int k);
        return result[s*1152 + k*72 +: 72];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic load_w(input logic [63:0] word, input int n);
        bus.w_valid = 1'b1;
        bus.w_data  = word;
        repeat (n) step();
        bus.w_valid = 1'b0;
        step();
    endtask

    task automatic feed(input logic [1:0] c, input logic [63:0] d,
                        input int n);
        bus.ctrl    = c;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        repeat (n) step();
        bus.i_valid = 1'b0;
    endtask

    task automatic end_run(input string tag);
        bus.ctrl = 2'd0;
        step();
        check({tag, "_rv"}, 72'(res_valid), 72'd1);
        check({tag, "_fin"}, 72'(finish), 72'd1);
        bus.ctrl = 2'd2;
        step();
        check({tag, "_rv_off"}, 72'(res_valid), 72'd0);
        check({tag, "_fin_hold"}, 72'(finish), 72'd1);
    endtask

    task automatic check_slots(input string tag, input int s0, input int s1,
                               input int k0, input int k1,
                               input logic [71:0] exp);
        for (int s = s0; s <= s1; s++) begin
            for (int k = k0; k <= k1; k++) begin
                check($sformatf("%s_s%0d_k%0d", tag, s, k),
                      slot_row(s, k), exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ctrl    = 2'd2;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        Wsize       = 2'd0;
        RLPadding   = 2'd0;
        stride      = 1'b0;
        wgroup      = 4'd0;
        wround      = 3'd5;

        step();
        check("rst_result", 72'(|result), 72'd0);
        check("rst_tmp0", tr[0], 72'd0);
        check("rst_rv", 72'(res_valid), 72'd0);
        check("rst_fin", 72'(finish), 72'd0);
        rst = 1'b1;
        step();

        load_w(P10, 18);
        feed(2'd2, P20, 2);
        check("hold_fin", 72'(finish), 72'd0);
        feed(2'd1, P20, 6);
        for (int k = 0; k < 16; k++)
            check($sformatf("t1_tmp%0d", k), tr[k], row(18, 6));
        check("t1_fin_run", 72'(finish), 72'd0);
        end_run("t1");
        check_slots("t1", 0, 5, 0, 15, row(18, 6));
        check_slots("t1_idle", 6, 7, 0, 0, 72'd0);

        do_reset();
        RLPadding = 2'd3;
        feed(2'd2, P20, 2);
        feed(2'd1, P20, 6);
        check("t2_tmp15", tr[15], prow(12, 18));
        end_run("t2");
        check_slots("t2", 0, 5, 0, 15, prow(12, 18));

        wgroup = 4'd1;
        feed(2'd2, P20, 2);
        feed(2'd1, P20, 6);
        end_run("t3");
        check_slots("t3", 0, 5, 0, 15, prow(24, 36));
        check_slots("t3_keep", 6, 7, 0, 15, 72'd0);

        wgroup    = 4'd0;
        RLPadding = 2'd0;
        load_w(PFF, 18);
        feed(2'd2, PFF, 2);
        feed(2'd1, PFF, 6);
        end_run("t4");
        check_slots("t4", 0, 5, 0, 15, row(511, 6));
        wgroup = 4'd1;
        feed(2'd2, PFF, 2);
        feed(2'd1, PFF, 6);
        end_run("t4acc");
        check_slots("t4acc", 0, 5, 0, 15, row(511, 6));

        do_reset();
        Wsize       = 2'd1;
        wgroup      = 4'd0;
        bus.w_valid = 1'b1;
        bus.w_data  = P10;
        repeat (25) step();
        bus.w_data  = PFF;
        step();
        bus.w_valid = 1'b0;
        step();
        feed(2'd1, P20, 4);
        check("t5_fill_k0", tr[0], 72'd0);
        feed(2'd1, P20, 1);
        check("t5_first_k0", tr[0], row(50, 4));
        feed(2'd1, P20, 3);
        check("t5_tmp7", tr[7], row(50, 4));
        check("t5_tmp8", tr[8], 72'd0);
        check("t5_tmp15", tr[15], 72'd0);
        end_run("t5");
        check_slots("t5", 0, 3, 0, 7, row(50, 4));
        check_slots("t5_hi", 0, 3, 8, 15, 72'd0);
        check_slots("t5_rest", 4, 4, 0, 0, 72'd0);

        do_reset();
        Wsize  = 2'd0;
        stride = 1'b1;
        feed(2'd2, P20, 2);
        feed(2'd1, P20, 1);
        check("t6_s0", slot_row(0, 0), row(18, 3));
        check("t6_tmp0", tr[0], row(18, 3));
        feed(2'd1, P20, 1);
        check("t6_skip", slot_row(1, 3), 72'd0);
        feed(2'd1, P20, 1);
        check("t6_s1", slot_row(1, 3), row(18, 3));
        check("t6_s2_empty", slot_row(2, 0), 72'd0);
        bus.i_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_result", 72'(|result), 72'd0);
        check("t6_rst_tmp0", tr[0], 72'd0);
        check("t6_rst_rv", 72'(res_valid), 72'd0);
        check("t6_rst_fin", 72'(finish), 72'd0);
        bus.i_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
